seg_scan_ctrl: RTL and testbench

Parametrised multi-digit seven-segment display controller for the Basys3 display path. Accepts a binary value on a load strobe, converts it to BCD with a sequential double-dabble engine, and time-multiplexes the digits onto shared active-low segment lines with one-hot active-low digit selects. It replaces the combinational converter, fixed 4-digit mux and free-running selector chain with one block that adds:
- a load/busy handshake
- leading-zero blanking
- overflow indication
- a clock-derived refresh rate

---
 rtl/seg_pkg.sv | 43 ++++
 rtl/seg_scan_ctrl_if.sv | 23 ++
 rtl/bcd_seq.sv | 99 +++++++++
 rtl/seg_scan_ctrl.sv | 93 +++++++++
 tb/tb_seg_scan_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants, segment decoding and converter state encoding for the
// seven-segment scan controller.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        CONV_IDLE   = 2'd0,
        CONV_SHIFT  = 2'd1,
        CONV_COMMIT = 2'd2
    } convState_e;

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles render as blank.
    function automatic logic [6:0] bcdToSeg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load/busy handshake plus display outputs of the scan controller.
interface seg_scan_ctrl_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic [BIN_W-1:0]  bin;
    logic              load;
    logic              busy;
    logic              ovf;
    logic [6:0]        hex;
    logic              dp;
    logic [DIGITS-1:0] dsel;

    modport master (
        output bin, load,
        input  busy, ovf, hex, dp, dsel
    );

    modport slave (
        input  bin, load,
        output busy, ovf, hex, dp, dsel
    );
endinterface

// File: rtl/bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, result and overflow
// published together in a single COMMIT cycle.
module bcd_seq
    import seg_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [BIN_W-1:0]      bin_i,
    output logic                  busy_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  ovf_o
);

    localparam int SW = 4 * (DIGITS + 1);
    localparam int CW = $clog2(BIN_W + 1);
    localparam int MW = (BIN_W > 64) ? BIN_W : 64;
    localparam longint unsigned LIMIT = pow10(DIGITS);
    // The extra nibble only catches overflow if the input cannot exceed 10^(DIGITS+1)-1.
    localparam bit CAP_EXCEEDED = (BIN_W >= 64) || ((64'd1 << BIN_W) > pow10(DIGITS + 1));

    convState_e            state_q, state_d;
    logic [BIN_W-1:0]      shift_q, shift_d;
    logic [BIN_W-1:0]      binCopy_q, binCopy_d;
    logic [SW-1:0]         scratch_q, scratch_d;
    logic [SW-1:0]         adjusted;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  ovf_q, ovf_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CONV_IDLE;
            shift_q   <= '0;
            binCopy_q <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            binCopy_q <= binCopy_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        binCopy_d = binCopy_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        adjusted  = scratch_q;
        for (int n = 0; n < DIGITS + 1; n++) begin
            if (scratch_q[4*n +: 4] >= 4'd5) begin
                adjusted[4*n +: 4] = scratch_q[4*n +: 4] + 4'd3;
            end
        end
        case (state_q)
            CONV_IDLE: begin
                if (load_i) begin
                    shift_d   = bin_i;
                    binCopy_d = bin_i;
                    scratch_d = '0;
                    cnt_d     = CW'(BIN_W);
                    state_d   = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                {scratch_d, shift_d} = {adjusted, shift_q} << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = CONV_COMMIT;
                end
            end
            CONV_COMMIT: begin
                bcd_d   = scratch_q[4*DIGITS-1:0];
                ovf_d   = (scratch_q[SW-1 -: 4] != 4'd0)
                       || (CAP_EXCEEDED && (MW'(binCopy_q) >= MW'(LIMIT)));
                state_d = CONV_IDLE;
            end
            default: state_d = CONV_IDLE;
        endcase
    end

    assign busy_o = (state_q != CONV_IDLE);
    assign bcd_o  = bcd_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Seven-segment display controller: sequential BCD conversion, leading-zero
// blanking, overflow dashes and a clock-derived digit scan.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int BIN_W      = 14,
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int BLANK_LZ   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    seg_scan_ctrl_if.slave bus
);

    localparam int TICKS = CLK_HZ / REFRESH_HZ;
    localparam int TW    = $clog2(TICKS);
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] dispBcd;
    logic                dispOvf;
    logic [6:0]          digitSeg [DIGITS];
    logic                higherZero;
    logic [3:0]          nib;

    logic [TW-1:0]       tick_q, tick_d;
    logic [IW-1:0]       scanIdx_q, scanIdx_d;
    logic [6:0]          hex_q, hex_d;
    logic [DIGITS-1:0]   dsel_q, dsel_d;

    bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (bus.load),
        .bin_i  (bus.bin),
        .busy_o (bus.busy),
        .bcd_o  (dispBcd),
        .ovf_o  (dispOvf)
    );

    // Walk from the top digit down so each digit knows whether everything above it is zero.
    always_comb begin
        higherZero = 1'b1;
        nib        = 4'd0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nib        = dispBcd[4*k +: 4];
            higherZero = higherZero && (nib == 4'd0);
            if (dispOvf) begin
                digitSeg[k] = SEG_DASH;
            end else if ((BLANK_LZ != 0) && (k != 0) && higherZero) begin
                digitSeg[k] = SEG_BLANK;
            end else begin
                digitSeg[k] = bcdToSeg(nib);
            end
        end
    end

    always_comb begin
        tick_d    = tick_q + TW'(1);
        scanIdx_d = scanIdx_q;
        if (tick_q == TW'(TICKS - 1)) begin
            tick_d    = '0;
            scanIdx_d = (scanIdx_q == IW'(DIGITS - 1)) ? '0 : scanIdx_q + IW'(1);
        end
        hex_d  = digitSeg[scanIdx_q];
        dsel_d = ~(DIGITS'(1) << scanIdx_q);
    end

    // hex and dsel come from the same index in the same edge so they never disagree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q    <= '0;
            scanIdx_q <= '0;
            hex_q     <= SEG_ZERO;
            dsel_q    <= ~DIGITS'(1);
        end else begin
            tick_q    <= tick_d;
            scanIdx_q <= scanIdx_d;
            hex_q     <= hex_d;
            dsel_q    <= dsel_d;
        end
    end

    assign bus.ovf  = dispOvf;
    assign bus.hex  = hex_q;
    assign bus.dsel = dsel_q;
    assign bus.dp   = 1'b1;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (blanking on/off) driven in lockstep
// and compared against a decimal-arithmetic model of the display.
module tb_seg_scan_ctrl;

    localparam int DIGITS     = 4;
    localparam int BIN_W      = 14;
    localparam int CLK_HZ     = 1000;
    localparam int REFRESH_HZ = 250;
    localparam int TICKS      = CLK_HZ / REFRESH_HZ;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   edgeCnt = 0;

    seg_scan_ctrl_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) busLz ();
    seg_scan_ctrl_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) busAll ();

    seg_scan_ctrl #(
        .DIGITS(DIGITS), .BIN_W(BIN_W), .CLK_HZ(CLK_HZ),
        .REFRESH_HZ(REFRESH_HZ), .BLANK_LZ(1)
    ) dutLz (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busLz)
    );

    seg_scan_ctrl #(
        .DIGITS(DIGITS), .BIN_W(BIN_W), .CLK_HZ(CLK_HZ),
        .REFRESH_HZ(REFRESH_HZ), .BLANK_LZ(0)
    ) dutAll (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busAll)
    );

    always #5 clk = ~clk;

    // Rising edges seen since reset was last released; the scan position follows from it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edgeCnt <= 0;
        else        edgeCnt <= edgeCnt + 1;
    end

    function automatic int pow10i(input int k);
        int r;
        r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] modelSeg(input int value, input int k, input bit blankLz);
        if (value >= pow10i(DIGITS)) return 7'b0111111;
        if (blankLz && k > 0 && value < pow10i(k)) return 7'b1111111;
        return glyph((value / pow10i(k)) % 10);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int value);
        busLz.bin   = BIN_W'(value);
        busAll.bin  = BIN_W'(value);
        busLz.load  = 1'b1;
        busAll.load = 1'b1;
        @(negedge clk);
        busLz.load  = 1'b0;
        busAll.load = 1'b0;
    endtask

    task automatic waitIdle(output int busyCycles);
        busyCycles = 0;
        while (busLz.busy === 1'b1 && busyCycles < 200) begin
            busyCycles++;
            @(negedge clk);
        end
        checkOutput("busyTimeout", 32'(busLz.busy), 32'(0));
        checkOutput("busyAll", 32'(busAll.busy), 32'(0));
    endtask

    task automatic checkFrame(input int value);
        logic [DIGITS-1:0] expDsel;
        int idx;
        for (int c = 0; c < DIGITS * TICKS; c++) begin
            idx     = (edgeCnt == 0) ? 0 : ((edgeCnt - 1) / TICKS) % DIGITS;
            expDsel = ~(DIGITS'(1) << idx);
            checkOutput("dsel", 32'(busLz.dsel), 32'(expDsel));
            checkOutput("dselAll", 32'(busAll.dsel), 32'(expDsel));
            checkOutput($sformatf("hexLz[%0d] v=%0d", idx, value), 32'(busLz.hex), 32'(modelSeg(value, idx, 1'b1)));
            checkOutput($sformatf("hexAll[%0d] v=%0d", idx, value), 32'(busAll.hex), 32'(modelSeg(value, idx, 1'b0)));
            @(negedge clk);
        end
        checkOutput("dp", 32'(busLz.dp), 32'(1));
    endtask

    task automatic loadAndCheck(input int value);
        int n;
        applyStimulus(value);
        waitIdle(n);
        checkOutput($sformatf("busyCycles v=%0d", value), 32'(n), 32'(BIN_W + 1));
        checkOutput($sformatf("ovf v=%0d", value), 32'(busLz.ovf), 32'(value >= pow10i(DIGITS)));
        checkOutput("ovfAll", 32'(busAll.ovf), 32'(value >= pow10i(DIGITS)));
        @(negedge clk);
        checkFrame(value);
    endtask

    task automatic checkResetState();
        checkOutput("rstDsel", 32'(busLz.dsel), 32'(4'b1110));
        checkOutput("rstHex", 32'(busLz.hex), 32'(7'b1000000));
        checkOutput("rstDp", 32'(busLz.dp), 32'(1));
        checkOutput("rstBusy", 32'(busLz.busy), 32'(0));
        checkOutput("rstOvf", 32'(busLz.ovf), 32'(0));
        checkOutput("rstHexAll", 32'(busAll.hex), 32'(7'b1000000));
    endtask

    initial begin
        int n;
        int v;
        busLz.load  = 1'b0;
        busAll.load = 1'b0;
        busLz.bin   = '0;
        busAll.bin  = '0;

        repeat (2) @(negedge clk);
        checkResetState();
        rst_n = 1'b1;
        checkFrame(0);

        loadAndCheck(1234);
        loadAndCheck(7);
        loadAndCheck(10000);
        loadAndCheck(9999);
        loadAndCheck(16383);
        loadAndCheck(0);

        $display("[TB] load while busy must be ignored");
        applyStimulus(42);
        repeat (3) @(negedge clk);
        applyStimulus(555);
        waitIdle(n);
        @(negedge clk);
        checkFrame(42);
        loadAndCheck(555);

        $display("[TB] reset during a conversion");
        applyStimulus(321);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkResetState();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("busyAfterRst", 32'(busLz.busy), 32'(0));
        checkFrame(0);
        loadAndCheck(321);

        $display("[TB] randomized values");
        for (int i = 0; i < 12; i++) begin
            v = (i % 2 == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 999));
            loadAndCheck(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
